oled_spi_tx: RTL and testbench
==============================

OLED_SPI_TX -- requirements
Module: oled_spi_tx

Interface
REQ-001 The module SHALL have one clock, clk_50, and one reset, rst_n, which SHALL be asynchronous and active-low.
REQ-002 Parameter CLK_DIV, default 5, SHALL set the number of clk_50 cycles per SCLK half-period (5 gives 5 MHz SCLK).
REQ-003 Port clk_50  input  1  system clock, 50 MHz.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port tx_valid  input  1  a byte is offered.
REQ-006 Port tx_data  input  8  byte to send, MSB first.
REQ-007 Port tx_dc  input  1  OLED D/C level for this byte (0 = command, 1 = data).
REQ-008 Port tx_last  input  1  release chip select after this byte.
REQ-009 Port tx_ready  output  1  byte accepted on this edge if tx_valid is also high.
REQ-010 Port oled_sclk  output  1  SPI clock, mode 0 (idle low).
REQ-011 Port oled_mosi  output  1  serial data.
REQ-012 Port oled_cs_n  output  1  active-low chip select.
REQ-013 Port oled_dc  output  1  OLED data/command select.

Function
REQ-014 The module SHALL use states IDLE, SHIFT, HOLD and DESEL, and tx_ready SHALL be high only in IDLE.
REQ-015 On a rising edge with tx_valid and tx_ready both high (cycle 0), the module SHALL latch tx_data, tx_dc and tx_last and enter SHIFT.
REQ-016 From cycle 1 the module SHALL drive oled_cs_n=0, oled_dc=latched tx_dc and oled_mosi=bit 7.
REQ-017 For each bit 7..0 the module SHALL hold oled_sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-018 oled_mosi SHALL change only in the cycle oled_sclk falls, and SHALL be stable across every rising edge.
REQ-019 After the bit-0 high phase, oled_sclk SHALL return low, giving 16*CLK_DIV shift cycles.
REQ-020 If the latched last bit is 0, the module SHALL return to IDLE with tx_ready high from cycle 16*CLK_DIV+1, and oled_cs_n and oled_dc SHALL stay unchanged.
REQ-021 If the latched last bit is 1, the module SHALL pass through HOLD for CLK_DIV cycles with oled_cs_n low, then DESEL for CLK_DIV cycles with oled_cs_n high, with tx_ready high from cycle 18*CLK_DIV+1.
REQ-022 tx_valid asserted outside IDLE SHALL be ignored, and changes to tx_data, tx_dc or tx_last after acceptance SHALL have no effect on the byte in flight.
REQ-023 Back-to-back bytes SHALL be supported: with tx_valid held high, the next byte SHALL be accepted on the first IDLE edge.
REQ-024 oled_dc SHALL update only at acceptance, never mid-byte.
REQ-025 The half-period counter SHALL be $clog2(CLK_DIV+1) bits wide and the bit counter 3 bits wide; neither SHALL wrap within a byte.
REQ-026 CLK_DIV < 1 SHALL be rejected at elaboration.

Reset
REQ-027 While rst_n is low, all outputs SHALL take these values immediately, independent of clk_50: oled_sclk=0, oled_mosi=0, oled_cs_n=1, oled_dc=0, state=IDLE, and tx_ready=1 once rst_n is high.
REQ-028 A reset mid-byte SHALL abort the transfer with no further SCLK edges, and the first byte after reset release SHALL start from bit 7.

Structure
REQ-029 Shared package oled_pkg SHALL hold the state enum, the default CLK_DIV and the SSD1306 command constants (display on 0xAF, display off 0xAE).
REQ-030 One sub-module, spi_clk_div, SHALL generate the half-period tick, and the shift FSM SHALL remain in oled_spi_tx.

Verification
REQ-031 CLK_DIV=2, send 0xA5 with dc=0, last=1: exactly 8 SCLK rising edges; MOSI sampled 1,0,1,0,0,1,0,1; cs_n low cycles 1-34; tx_ready back at cycle 37.
REQ-032 CLK_DIV=2, stream 0x01, 0x02, 0xFF with dc=1 and last only on 0xFF: cs_n low throughout; 24 rising edges; tx_ready pulses at cycles 33 and 66; dc=1 throughout.
REQ-033 Change tx_data to 0x00 and toggle tx_valid mid-byte while sending 0x3C: sampled bits remain 0x3C and no second byte starts.
REQ-034 Assert rst_n=0 after the 4th rising edge of 0xF0: sclk=0 and cs_n=1 within the same cycle; after release, send 0x81 and it is sampled as 0x81.
REQ-035 CLK_DIV=1, send 0xAF with last=1: SCLK period is 2 cycles; tx_ready returns at cycle 19.
REQ-036 Command-then-data, 0xAE (dc=0) then 0x55 (dc=1): dc switches only at the second acceptance and is stable during all 0x55 edges.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared types and constants for the SSD1306 OLED SPI transmitter.
package oled_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    DESEL
  } state_e;

  localparam int CLK_DIV_DEFAULT = 5;

  localparam logic [7:0] SSD1306_DISPLAY_ON  = 8'hAF;
  localparam logic [7:0] SSD1306_DISPLAY_OFF = 8'hAE;

endpackage

// File: rtl/oled_spi_tx_if.sv
// Byte-level valid/ready handshake into the OLED SPI transmitter.
interface oled_spi_tx_if;

  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_dc;
  logic       tx_last;
  logic       tx_ready;

  modport master (output tx_valid, output tx_data, output tx_dc, output tx_last,
                  input  tx_ready);

  modport slave  (input  tx_valid, input  tx_data, input  tx_dc, input  tx_last,
                  output tx_ready);

endinterface

// File: rtl/spi_clk_div.sv
// Half-period tick generator: one-cycle tick every CLK_DIV enabled cycles.
module spi_clk_div
  import oled_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk_50,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("spi_clk_div: CLK_DIV must be at least 1");
  end

  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter is held at zero while disabled so every phase starts aligned.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/oled_spi_tx.sv
// SPI mode-0 byte transmitter for an SSD1306 OLED with D/C and chip-select control.
module oled_spi_tx
  import oled_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic         clk_50,
  input  logic         rst_n,
  oled_spi_tx_if.slave tx,
  output logic         oled_sclk,
  output logic         oled_mosi,
  output logic         oled_cs_n,
  output logic         oled_dc
);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("oled_spi_tx: CLK_DIV must be at least 1");
  end

  state_e     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       last_q, last_d;
  logic       sclk_q, sclk_d;
  logic       cs_n_q, cs_n_d;
  logic       dc_q, dc_d;
  logic       tick;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk_50 (clk_50),
    .rst_n  (rst_n),
    .en     (state_q != IDLE),
    .tick   (tick)
  );

  assign tx.tx_ready = (state_q == IDLE);
  assign oled_sclk   = sclk_q;
  assign oled_mosi   = shreg_q[7];
  assign oled_cs_n   = cs_n_q;
  assign oled_dc     = dc_q;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    last_d    = last_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    dc_d      = dc_q;
    unique case (state_q)
      IDLE: begin
        if (tx.tx_valid) begin
          shreg_d   = tx.tx_data;
          dc_d      = tx.tx_dc;
          last_d    = tx.tx_last;
          cs_n_d    = 1'b0;
          sclk_d    = 1'b0;
          bit_cnt_d = 3'd7;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // MOSI advances only together with the falling SCLK edge.
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_cnt_q == 3'd0) begin
              state_d = last_q ? HOLD : IDLE;
            end else begin
              bit_cnt_d = bit_cnt_q - 1'b1;
              shreg_d   = {shreg_q[6:0], 1'b0};
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          cs_n_d  = 1'b1;
          state_d = DESEL;
        end
      end
      DESEL: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      last_q    <= 1'b0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      dc_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      last_q    <= last_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      dc_q      <= dc_d;
    end
  end

endmodule

// File: tb/tb_oled_spi_tx.sv
// Self-checking bench for oled_spi_tx at CLK_DIV=2 and CLK_DIV=1, directed and random traffic.
module tb_oled_spi_tx;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst_n;
  logic       sel;
  logic       tv;
  logic [7:0] td;
  logic       tdc;
  logic       tl;

  oled_spi_tx_if if2 ();
  oled_spi_tx_if if1 ();

  assign if2.tx_valid = tv & ~sel;
  assign if2.tx_data  = td;
  assign if2.tx_dc    = tdc;
  assign if2.tx_last  = tl;
  assign if1.tx_valid = tv & sel;
  assign if1.tx_data  = td;
  assign if1.tx_dc    = tdc;
  assign if1.tx_last  = tl;

  logic sclk2, mosi2, cs_n2, dc2;
  logic sclk1, mosi1, cs_n1, dc1;

  oled_spi_tx #(.CLK_DIV(2)) u_dut2 (
    .clk_50    (clk),
    .rst_n     (rst_n),
    .tx        (if2.slave),
    .oled_sclk (sclk2),
    .oled_mosi (mosi2),
    .oled_cs_n (cs_n2),
    .oled_dc   (dc2)
  );

  oled_spi_tx #(.CLK_DIV(1)) u_dut1 (
    .clk_50    (clk),
    .rst_n     (rst_n),
    .tx        (if1.slave),
    .oled_sclk (sclk1),
    .oled_mosi (mosi1),
    .oled_cs_n (cs_n1),
    .oled_dc   (dc1)
  );

  logic o_sclk, o_mosi, o_cs_n, o_dc, o_ready;
  assign o_sclk  = sel ? sclk1 : sclk2;
  assign o_mosi  = sel ? mosi1 : mosi2;
  assign o_cs_n  = sel ? cs_n1 : cs_n2;
  assign o_dc    = sel ? dc1   : dc2;
  assign o_ready = sel ? if1.tx_ready : if2.tx_ready;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sends one byte starting at a negedge; returns at the negedge where tx_ready reappears.
  // With stream set, the next byte is presented with tx_valid held high.
  task automatic send_one(input logic [7:0] data, input logic dc, input logic last,
                          input bit stream, input logic [7:0] nd, input logic ndc,
                          input logic nl, input bit disturb);
    int unsigned d, exp_rdy, waited, cyc, rises, cs_low, mosi_bad, dc_bad;
    logic [7:0]  cap;
    logic        prev_sclk, prev_mosi;
    d       = sel ? 1 : 2;
    exp_rdy = 16 * d + 1 + (last ? 2 * d : 0);
    tv = 1'b1; td = data; tdc = dc; tl = last;
    waited = 0;
    while (!o_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check_eq("accept_bound", 32'(waited < 100), 1);
    prev_sclk = o_sclk;
    prev_mosi = o_mosi;
    @(posedge clk);
    #1;
    if (stream) begin
      td = nd; tdc = ndc; tl = nl;
    end else if (disturb) begin
      td = 8'h00; tdc = ~dc; tl = ~last; tv = 1'b0;
    end else begin
      tv = 1'b0; td = 8'($urandom); tdc = ~dc; tl = ~last;
    end
    cyc = 0; rises = 0; cs_low = 0; mosi_bad = 0; dc_bad = 0; cap = '0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (disturb) tv = (cyc + 1 < 16 * d) ? ~tv : 1'b0;
      if (o_sclk && !prev_sclk) begin
        rises++;
        cap = {cap[6:0], o_mosi};
      end
      if (cyc > 1 && o_mosi !== prev_mosi && !(prev_sclk && !o_sclk)) mosi_bad++;
      prev_sclk = o_sclk;
      prev_mosi = o_mosi;
      if (o_ready) break;
      if (!o_cs_n) cs_low++;
      if (o_dc !== dc) dc_bad++;
    end
    check_eq("ready_cycle", cyc, exp_rdy);
    check_eq("mosi_byte", cap, data);
    check_eq("sclk_rises", rises, 8);
    check_eq("mosi_stable", mosi_bad, 0);
    check_eq("dc_stable", dc_bad, 0);
    check_eq("cs_low_cycles", cs_low, last ? 17 * d : 16 * d);
    check_eq("cs_after", o_cs_n, last);
    check_eq("dc_after", o_dc, dc);
    check_eq("sclk_idle", o_sclk, 0);
  endtask

  task automatic check_quiet(input string tag, input int unsigned ncyc);
    int unsigned bad;
    bad = 0;
    for (int unsigned k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (!o_ready || o_sclk) bad++;
    end
    check_eq(tag, bad, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned rises, cyc, hi, len;
    logic        prev_sclk;
    logic [7:0]  bd [0:4];
    logic        bdc [0:4];
    logic        bl [0:4];

    rst_n = 1'b0; sel = 1'b0; tv = 1'b0; td = '0; tdc = 1'b0; tl = 1'b0;
    #25;
    check_eq("rst_sclk", o_sclk, 0);
    check_eq("rst_mosi", o_mosi, 0);
    check_eq("rst_cs_n", o_cs_n, 1);
    check_eq("rst_dc", o_dc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", o_ready, 1);

    // Single command byte with deselect, CLK_DIV=2
    send_one(8'hA5, 1'b0, 1'b1, 0, '0, 1'b0, 1'b0, 0);

    // Streamed data bytes, chip select held until the last
    send_one(8'h01, 1'b1, 1'b0, 1, 8'h02, 1'b1, 1'b0, 0);
    send_one(8'h02, 1'b1, 1'b0, 1, 8'hFF, 1'b1, 1'b1, 0);
    send_one(8'hFF, 1'b1, 1'b1, 0, '0, 1'b0, 1'b0, 0);

    // Input churn while busy must not affect the byte or start another
    send_one(8'h3C, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 1);
    check_quiet("no_second_byte", 8);

    // Command then data: D/C flips only at the second acceptance
    send_one(8'hAE, 1'b0, 1'b0, 1, 8'h55, 1'b1, 1'b1, 0);
    send_one(8'h55, 1'b1, 1'b1, 0, '0, 1'b0, 1'b0, 0);

    // Reset mid-byte
    tv = 1'b1; td = 8'hF0; tdc = 1'b1; tl = 1'b1;
    cyc = 0;
    while (!o_ready && cyc < 100) begin @(negedge clk); cyc++; end
    @(posedge clk);
    #1 tv = 1'b0;
    rises = 0; cyc = 0; prev_sclk = 1'b0;
    while (rises < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (o_sclk && !prev_sclk) rises++;
      prev_sclk = o_sclk;
    end
    check_eq("abort_rises", rises, 4);
    #3 rst_n = 1'b0;
    #1;
    check_eq("abort_sclk", o_sclk, 0);
    check_eq("abort_cs_n", o_cs_n, 1);
    check_eq("abort_dc", o_dc, 0);
    hi = 0;
    for (int unsigned k = 0; k < 10; k++) begin
      @(negedge clk);
      if (o_sclk || !o_cs_n) hi++;
    end
    check_eq("abort_quiet", hi, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("abort_ready", o_ready, 1);
    send_one(8'h81, 1'b0, 1'b1, 0, '0, 1'b0, 1'b0, 0);

    // CLK_DIV=1 instance
    sel = 1'b1;
    @(negedge clk);
    send_one(8'hAF, 1'b0, 1'b1, 0, '0, 1'b0, 1'b0, 0);

    // Random bursts on either instance
    for (int b = 0; b < 8; b++) begin
      sel = 1'($urandom_range(0, 1));
      @(negedge clk);
      len = $urandom_range(1, 4);
      for (int i = 0; i < 5; i++) begin
        bd[i]  = 8'($urandom);
        bdc[i] = 1'($urandom_range(0, 1));
        bl[i]  = (i == int'(len) - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      for (int i = 0; i < int'(len); i++) begin
        if (i + 1 < int'(len))
          send_one(bd[i], bdc[i], bl[i], 1, bd[i+1], bdc[i+1], bl[i+1], 0);
        else
          send_one(bd[i], bdc[i], bl[i], 0, '0, 1'b0, 1'b0, 0);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
